// File: rtl/iob_soc_opencryptolinux_mem_arbiter.sv
// rtl/iob_soc_opencryptolinux_mem_arbiter.sv - two-master round-robin arbiter onto one shared IOb memory port
module iob_soc_opencryptolinux_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,

    input  logic                m0_iob_avalid_i,
    input  logic [ADDR_W-1:0]   m0_iob_addr_i,
    input  logic [DATA_W-1:0]   m0_iob_wdata_i,
    input  logic [DATA_W/8-1:0] m0_iob_wstrb_i,
    output logic [DATA_W-1:0]   m0_iob_rdata_o,
    output logic                m0_iob_rvalid_o,
    output logic                m0_iob_ready_o,

    input  logic                m1_iob_avalid_i,
    input  logic [ADDR_W-1:0]   m1_iob_addr_i,
    input  logic [DATA_W-1:0]   m1_iob_wdata_i,
    input  logic [DATA_W/8-1:0] m1_iob_wstrb_i,
    output logic [DATA_W-1:0]   m1_iob_rdata_o,
    output logic                m1_iob_rvalid_o,
    output logic                m1_iob_ready_o,

    output logic                s_iob_avalid_o,
    output logic [ADDR_W-1:0]   s_iob_addr_o,
    output logic [DATA_W-1:0]   s_iob_wdata_o,
    output logic [DATA_W/8-1:0] s_iob_wstrb_o,
    input  logic [DATA_W-1:0]   s_iob_rdata_i,
    input  logic                s_iob_rvalid_i,
    input  logic                s_iob_ready_i,

    output logic [1:0]          grant_o
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q,  last_d;

    logic              sel;
    logic              sel_avalid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic              pick_m1;
    logic              fwd_ready;
    logic              fwd_rvalid;
    logic [DATA_W-1:0] fwd_rdata;

    // Request mux follows the registered grant, so the slave only ever sees one master.
    assign sel        = grant_q[1];
    assign sel_avalid = sel ? m1_iob_avalid_i : m0_iob_avalid_i;
    assign sel_addr   = sel ? m1_iob_addr_i   : m0_iob_addr_i;
    assign sel_wdata  = sel ? m1_iob_wdata_i  : m0_iob_wdata_i;
    assign sel_wstrb  = sel ? m1_iob_wstrb_i  : m0_iob_wstrb_i;

    // On a tie the master that did not win last time gets the bus.
    assign pick_m1 = m1_iob_avalid_i & (~m0_iob_avalid_i | ~last_q);

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        s_iob_avalid_o = 1'b0;
        s_iob_addr_o   = '0;
        s_iob_wdata_o  = '0;
        s_iob_wstrb_o  = '0;
        fwd_ready      = 1'b0;
        fwd_rvalid     = 1'b0;
        fwd_rdata      = '0;

        case (state_q)
            IDLE: begin
                grant_d = 2'b00;
                if (m0_iob_avalid_i || m1_iob_avalid_i) begin
                    grant_d = pick_m1 ? 2'b10 : 2'b01;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                s_iob_avalid_o = sel_avalid;
                s_iob_addr_o   = sel_addr;
                s_iob_wdata_o  = sel_wdata;
                s_iob_wstrb_o  = sel_wstrb;
                fwd_ready      = s_iob_ready_i;
                if (!sel_avalid) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = sel;
                end else if (s_iob_ready_i) begin
                    if (sel_wstrb != '0) begin
                        state_d = IDLE;
                        grant_d = 2'b00;
                        last_d  = sel;
                    end else begin
                        state_d = RDATA;
                    end
                end
            end
            RDATA: begin
                fwd_rvalid = s_iob_rvalid_i;
                fwd_rdata  = s_iob_rdata_i;
                if (s_iob_rvalid_i) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = sel;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase

        // Outputs are held quiet while reset is asserted, whatever the old state was.
        if (rst_i) begin
            s_iob_avalid_o = 1'b0;
            s_iob_addr_o   = '0;
            s_iob_wdata_o  = '0;
            s_iob_wstrb_o  = '0;
            fwd_ready      = 1'b0;
            fwd_rvalid     = 1'b0;
            fwd_rdata      = '0;
        end
    end

    always_comb begin
        m0_iob_ready_o  = grant_q[0] & fwd_ready;
        m0_iob_rvalid_o = grant_q[0] & fwd_rvalid;
        m0_iob_rdata_o  = grant_q[0] ? fwd_rdata : '0;
        m1_iob_ready_o  = grant_q[1] & fwd_ready;
        m1_iob_rvalid_o = grant_q[1] & fwd_rvalid;
        m1_iob_rdata_o  = grant_q[1] ? fwd_rdata : '0;
        grant_o         = rst_i ? 2'b00 : grant_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
        end else if (cke_i) begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule
